// File: rtl/br_update_queue.sv
// br_update_queue: branch-result FIFO draining predictor updates plus a
// held mispredict recovery request. Optional: BR_UPDATE_QUEUE_STATS_EN.
module br_update_queue #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int PC_W = 32,
  parameter int PHT_IDX_W = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ISSUE_WIDTH-1:0]         brValid,
  input  logic [ISSUE_WIDTH*PC_W-1:0]    brAddr,
  input  logic [ISSUE_WIDTH*PC_W-1:0]    brNext,
  input  logic [ISSUE_WIDTH-1:0]         brTaken,
  input  logic [ISSUE_WIDTH-1:0]         brIsCond,
  input  logic [ISSUE_WIDTH-1:0]         brMispred,
  input  logic [ISSUE_WIDTH*PHT_IDX_W-1:0] brPhtIdx,
  input  logic [ISSUE_WIDTH*2-1:0]       brPhtPrev,
  input  logic                           flushAll,
  output logic                           updValid,
  input  logic                           updReady,
  output logic [PC_W-1:0]                updAddr,
  output logic [PC_W-1:0]                updTarget,
  output logic                           updTaken,
  output logic                           updIsCond,
  output logic [PHT_IDX_W-1:0]           updPhtIdx,
  output logic [1:0]                     updPhtNew,
  output logic                           nearFull,
  output logic                           recReq,
  output logic [PC_W-1:0]                recPC,
  input  logic                           recAck,
  output logic [15:0]                    statMispred,
  output logic [15:0]                    statDrop
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]      addr;
    logic [PC_W-1:0]      target;
    logic                 taken;
    logic                 isCond;
    logic [PHT_IDX_W-1:0] phtIdx;
    logic [1:0]           phtNew;
  } entry_t;

  typedef enum logic {IDLE, REQ} rec_state_t;

  entry_t                 mem [DEPTH];
  entry_t                 laneEnt [ISSUE_WIDTH];
  entry_t                 hd;
  logic [PW-1:0]          slot [ISSUE_WIDTH];
  logic [PW-1:0]          head, tail, used, freeSlots;
  logic [PW-1:0]          nValid, nAccept;
  logic [ISSUE_WIDTH-1:0] accept;
  logic                   deq;

  rec_state_t             state, stateNext;
  logic                   anyMis, recCapture;
  logic [PC_W-1:0]        misPC;

  function automatic logic [1:0] nextCtr(
    input logic [1:0] prev,
    input logic       taken,
    input logic       isCond
  );
    logic [1:0] r;
    r = prev;
    if (isCond && taken && prev != 2'd3)
      r = prev + 2'd1;
    else if (isCond && !taken && prev != 2'd0)
      r = prev - 2'd1;
    return r;
  endfunction

  assign used      = tail - head;
  assign freeSlots = PW'(DEPTH) - used;
  assign updValid  = (used != '0);
  assign nearFull  = freeSlots < PW'(ISSUE_WIDTH);
  assign deq       = updValid && updReady;

  assign hd        = mem[head[AW-1:0]];
  assign updAddr   = hd.addr;
  assign updTarget = hd.target;
  assign updTaken  = hd.taken;
  assign updIsCond = hd.isCond;
  assign updPhtIdx = hd.phtIdx;
  assign updPhtNew = hd.phtNew;

  // valid lanes are compacted; only the lowest ones that fit are kept
  always_comb begin
    nValid  = '0;
    nAccept = '0;
    accept  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      slot[i]           = tail + nValid;
      laneEnt[i].addr   = brAddr[i*PC_W +: PC_W];
      laneEnt[i].target = brNext[i*PC_W +: PC_W];
      laneEnt[i].taken  = brTaken[i];
      laneEnt[i].isCond = brIsCond[i];
      laneEnt[i].phtIdx = brPhtIdx[i*PHT_IDX_W +: PHT_IDX_W];
      laneEnt[i].phtNew = nextCtr(brPhtPrev[i*2 +: 2],
                                  brTaken[i], brIsCond[i]);
      if (brValid[i]) begin
        if (nValid < freeSlots) begin
          accept[i] = 1'b1;
          nAccept   = nAccept + PW'(1);
        end
        nValid = nValid + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else if (flushAll) begin
      head <= tail;
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (accept[i])
          mem[slot[i][AW-1:0]] <= laneEnt[i];
      tail <= tail + nAccept;
      if (deq)
        head <= head + PW'(1);
    end
  end

  always_comb begin
    anyMis = 1'b0;
    misPC  = '0;
    for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (brValid[i] && brMispred[i]) begin
        anyMis = 1'b1;
        misPC  = brNext[i*PC_W +: PC_W];
      end
    end
    stateNext  = state;
    recCapture = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyMis) begin
          stateNext  = REQ;
          recCapture = 1'b1;
        end
      end
      REQ: begin
        if (recAck)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      recPC <= '0;
    end else begin
      state <= stateNext;
      if (recCapture)
        recPC <= misPC;
    end
  end

  assign recReq = (state == REQ);

`ifdef BR_UPDATE_QUEUE_STATS_EN
  logic [15:0] mispredCnt, dropCnt;
  logic [PW-1:0] dropLanes;
  logic [16:0] dropSum;

  assign dropLanes = flushAll ? '0 : nValid - nAccept;
  assign dropSum   = {1'b0, dropCnt} + 17'(dropLanes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredCnt <= '0;
      dropCnt    <= '0;
    end else begin
      if (recCapture && mispredCnt != 16'hFFFF)
        mispredCnt <= mispredCnt + 16'd1;
      dropCnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end
  end

  assign statMispred = mispredCnt;
  assign statDrop    = dropCnt;
`else
  assign statMispred = '0;
  assign statDrop    = '0;
`endif

endmodule
